// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery exponentiation control path.
//   - default operand/exponent widths (256), reduced to 4 when the
//     MODEXP_TEST macro is defined, for small test builds
//   - FSM state encoding of mont_modexp_ctrl
package mont_pkg;

`ifdef MODEXP_TEST
  localparam int WID_DEF  = 4;
  localparam int EWID_DEF = 4;
`else
  localparam int WID_DEF  = 256;
  localparam int EWID_DEF = 256;
`endif

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SQR_REQ  = 3'd1;
  localparam logic [2:0] ST_SQR_WAIT = 3'd2;
  localparam logic [2:0] ST_MUL_REQ  = 3'd3;
  localparam logic [2:0] ST_MUL_WAIT = 3'd4;
  localparam logic [2:0] ST_NEXT     = 3'd5;
  localparam logic [2:0] ST_FIN      = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    SQR_REQ  = ST_SQR_REQ,
    SQR_WAIT = ST_SQR_WAIT,
    MUL_REQ  = ST_MUL_REQ,
    MUL_WAIT = ST_MUL_WAIT,
    NEXT     = ST_NEXT,
    FIN      = ST_FIN
  } state_t;

endpackage

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer for the Montgomery product
// unit. Computes base^expo in the Montgomery domain, scanning expo from
// bit EWID-1 down to bit 0. Domain conversion happens outside this block.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   start         one-cycle request, accepted only while idle (busy=0)
//   base/expo/one_m  operands, captured when start is accepted
//   busy          high from the cycle after acceptance until completion
//   done          one-cycle pulse, result valid
//   result        final accumulator, held until the next accepted start
//   mm_start      one-cycle request to the Montgomery multiplier
//   mm_a/mm_b     registered multiplier operands, stable until next mm_start
//   mm_r/mm_done  multiplier product and completion pulse
//
// Configuration:
//   MODEXP_CT_EN  constant-time mode: a multiply is issued for every
//                 exponent bit; its product is kept only when the bit is 1.
module mont_modexp_ctrl
  import mont_pkg::*;
#(
  parameter int WID  = WID_DEF,
  parameter int EWID = EWID_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [WID-1:0]  base,
  input  logic [EWID-1:0] expo,
  input  logic [WID-1:0]  one_m,
  output logic            busy,
  output logic            done,
  output logic [WID-1:0]  result,
  output logic            mm_start,
  output logic [WID-1:0]  mm_a,
  output logic [WID-1:0]  mm_b,
  input  logic [WID-1:0]  mm_r,
  input  logic            mm_done
);

  localparam int IW = (EWID > 1) ? $clog2(EWID) : 1;

  state_t          state, state_d;
  logic [WID-1:0]  base_q, base_d;
  logic [EWID-1:0] expo_q, expo_d;
  logic [WID-1:0]  acc, acc_d;
  logic [IW-1:0]   idx, idx_d;
  logic            busy_d, done_d, mm_start_d;
  logic [WID-1:0]  result_d, mm_a_d, mm_b_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      base_q   <= '0;
      expo_q   <= '0;
      acc      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      mm_start <= 1'b0;
      mm_a     <= '0;
      mm_b     <= '0;
    end else begin
      state    <= state_d;
      base_q   <= base_d;
      expo_q   <= expo_d;
      acc      <= acc_d;
      idx      <= idx_d;
      busy     <= busy_d;
      done     <= done_d;
      result   <= result_d;
      mm_start <= mm_start_d;
      mm_a     <= mm_a_d;
      mm_b     <= mm_b_d;
    end
  end

  // The *_REQ states load operands and raise mm_start in the same edge, so
  // the multiplier sees a request whose operands are already settled; they
  // then hold until the next request, covering the whole wait window.
  always_comb begin
    state_d    = state;
    base_d     = base_q;
    expo_d     = expo_q;
    acc_d      = acc;
    idx_d      = idx;
    busy_d     = busy;
    done_d     = 1'b0;
    result_d   = result;
    mm_start_d = 1'b0;
    mm_a_d     = mm_a;
    mm_b_d     = mm_b;
    case (state)
      IDLE: begin
        if (start) begin
          base_d  = base;
          expo_d  = expo;
          acc_d   = one_m;
          idx_d   = IW'(EWID - 1);
          busy_d  = 1'b1;
          state_d = SQR_REQ;
        end
      end
      SQR_REQ: begin
        mm_a_d     = acc;
        mm_b_d     = acc;
        mm_start_d = 1'b1;
        state_d    = SQR_WAIT;
      end
      SQR_WAIT: begin
        if (mm_done) begin
          acc_d = mm_r;
`ifdef MODEXP_CT_EN
          state_d = MUL_REQ;
`else
          state_d = expo_q[idx] ? MUL_REQ : NEXT;
`endif
        end
      end
      MUL_REQ: begin
        mm_a_d     = acc;
        mm_b_d     = base_q;
        mm_start_d = 1'b1;
        state_d    = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mm_done) begin
`ifdef MODEXP_CT_EN
          // Dummy multiply on zero bits keeps timing independent of expo.
          if (expo_q[idx]) acc_d = mm_r;
`else
          acc_d = mm_r;
`endif
          state_d = NEXT;
        end
      end
      NEXT: begin
        // Test before decrementing so the index never wraps.
        if (idx == '0) begin
          state_d = FIN;
        end else begin
          idx_d   = idx - IW'(1);
          state_d = SQR_REQ;
        end
      end
      FIN: begin
        result_d = acc;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
module tb_mont_modexp_ctrl;

  localparam int WID  = 4;
  localparam int EWID = 4;
  localparam int MODP = 13;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [WID-1:0]  base;
  logic [EWID-1:0] expo;
  logic [WID-1:0]  one_m;
  logic            busy, done, mm_start;
  logic [WID-1:0]  result, mm_a, mm_b;
  logic [WID-1:0]  mm_r;
  logic            mm_done;

  mont_modexp_ctrl #(.WID(WID), .EWID(EWID)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .expo(expo),
    .one_m(one_m), .busy(busy), .done(done), .result(result),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b), .mm_r(mm_r),
    .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain modular arithmetic over the exponent bits.
  typedef struct { int a; int b; } pair_t;
  pair_t exp_ops[$];
  int    exp_res;

  task automatic build_model(input int b, input int e, input int one);
    int acc;
    pair_t p;
    exp_ops.delete();
    acc = one;
    for (int i = EWID - 1; i >= 0; i--) begin
      p.a = acc; p.b = acc; exp_ops.push_back(p);
      acc = (acc * acc) % MODP;
`ifdef MODEXP_CT_EN
      p.a = acc; p.b = b; exp_ops.push_back(p);
      if (((e >> i) & 1) == 1) acc = (acc * b) % MODP;
`else
      if (((e >> i) & 1) == 1) begin
        p.a = acc; p.b = b; exp_ops.push_back(p);
        acc = (acc * b) % MODP;
      end
`endif
    end
    exp_res = acc;
  endtask

  // Behavioural multiplier: product mod 13, done 3 cycles after request.
  int   n_starts = 0;
  int   n_done = 0;
  bit   spur = 1'b0;
  bit   pend;
  int   cnt;
  logic [WID-1:0] prod;

  initial begin
    mm_done = 1'b0; mm_r = '0; pend = 1'b0; cnt = 0; prod = '0;
    forever begin
      @(negedge clk);
      mm_done = 1'b0;
      if (!rst) begin
        pend = 1'b0; cnt = 0;
      end else begin
        if (spur) begin
          mm_done = 1'b1; mm_r = 4'd9; spur = 1'b0;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mm_done = 1'b1; mm_r = prod; pend = 1'b0;
          end
        end
        if (mm_start) begin
          pend = 1'b1; cnt = 3;
          prod = WID'((int'(mm_a) * int'(mm_b)) % MODP);
          n_starts++;
        end
      end
    end
  end

  // Continuous checking: operand sequence, operand stability, results.
  bit   have_cap = 1'b0;
  logic [WID-1:0] cap_a, cap_b;

  initial begin
    pair_t p;
    forever begin
      @(negedge clk);
      if (!rst) begin
        have_cap = 1'b0;
      end else begin
        if (mm_start) begin
          if (exp_ops.size() == 0) begin
            chk("unexpected_mm_start", 1, 0);
          end else begin
            p = exp_ops.pop_front();
            chk("mm_a", int'(mm_a), p.a);
            chk("mm_b", int'(mm_b), p.b);
          end
          cap_a = mm_a; cap_b = mm_b; have_cap = 1'b1;
        end else if (have_cap) begin
          chk("mm_a_stable", int'(mm_a), int'(cap_a));
          chk("mm_b_stable", int'(mm_b), int'(cap_b));
        end
        if (done) begin
          n_done++;
          chk("result", int'(result), exp_res);
          chk("busy_at_done", int'(busy), 0);
          chk("ops_left", exp_ops.size(), 0);
        end
      end
    end
  end

  task automatic pulse_start(input int b, input int e);
    @(negedge clk);
    base = WID'(b); expo = EWID'(e); one_m = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Launch one operation and wait for done; returns the cycle count.
  task automatic run_op(input int b, input int e, output int lat);
    int s0;
    bit seen;
    build_model(b, e, 1);
    s0 = n_starts;
    pulse_start(b, e);
    lat = 1; seen = 1'b0;
    for (int k = 0; k < 500 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    if (!seen) chk("done_timeout", 0, 1);
    lat = (n_starts - s0) * 1000 + lat;
  endtask

  int l0, l3, l15, lt, d0, sa, sb, sr, ss;

  initial begin
    rst = 1'b0; start = 1'b0; base = '0; expo = '0; one_m = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_mm_start", int'(mm_start), 0);
    chk("rst_mm_a", int'(mm_a), 0);
    chk("rst_mm_b", int'(mm_b), 0);
    rst = 1'b1;
    @(negedge clk);

    // Model pinned against hand-computed values.
    build_model(5, 3, 1);  chk("model_e3", exp_res, 8);
    build_model(5, 0, 1);  chk("model_e0", exp_res, 1);
    build_model(5, 15, 1); chk("model_e15", exp_res, 8);

    // 1. base=5 expo=3
    d0 = n_done;
    run_op(5, 3, l3);
    @(negedge clk);
    chk("t1_result", int'(result), 8);
    chk("t1_done_once", n_done - d0, 1);
`ifdef MODEXP_CT_EN
    chk("t1_starts", l3 / 1000, 8);
`else
    chk("t1_starts", l3 / 1000, 6);
`endif

    // 2. expo=0
    run_op(5, 0, l0);
    @(negedge clk);
    chk("t2_result", int'(result), 1);
`ifdef MODEXP_CT_EN
    chk("t2_starts", l0 / 1000, 8);
`else
    chk("t2_starts", l0 / 1000, 4);
`endif

    // 3. expo=15
    run_op(5, 15, l15);
    @(negedge clk);
    chk("t3_result", int'(result), 8);
    chk("t3_starts", l15 / 1000, 8);
`ifdef MODEXP_CT_EN
    chk("t3_ct_lat_e0", l0 % 1000, l15 % 1000);
    chk("t3_ct_lat_e3", l3 % 1000, l15 % 1000);
`else
    chk("t3_mul_cost", (l15 % 1000) - (l3 % 1000), (l3 % 1000) - (l0 % 1000));
`endif

    // 4. start while busy is ignored
    build_model(5, 3, 1);
    d0 = n_done;
    pulse_start(5, 3);
    repeat (4) @(negedge clk);
    chk("t4_busy", int'(busy), 1);
    base = 4'd7; expo = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 500 && n_done == d0; k++) @(negedge clk);
    @(negedge clk);
    chk("t4_result", int'(result), 8);
    chk("t4_done_once", n_done - d0, 1);

    // 5. reset during the third multiply wait
    build_model(5, 15, 1);
    d0 = n_done;
    ss = n_starts;
    pulse_start(5, 15);
    for (int k = 0; k < 500 && (n_starts - ss) < 6; k++) @(negedge clk);
    chk("t5_reach_mul3", n_starts - ss, 6);
    @(negedge clk);
    rst = 1'b0;
    exp_ops.delete();
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_result", int'(result), 0);
    chk("t5_mm_start", int'(mm_start), 0);
    chk("t5_mm_a", int'(mm_a), 0);
    chk("t5_mm_b", int'(mm_b), 0);
    rst = 1'b1;
    sr = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) sr++;
    end
    chk("t5_no_done", sr + (n_done - d0), 0);
    run_op(5, 3, lt);
    @(negedge clk);
    chk("t5_restart_result", int'(result), 8);

    // 6. spurious mm_done while idle
    sa = int'(mm_a); sb = int'(mm_b); sr = int'(result);
    ss = n_starts; d0 = n_done;
    spur = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_busy", int'(busy), 0);
    chk("t6_no_start", n_starts - ss, 0);
    chk("t6_no_done", n_done - d0, 0);
    chk("t6_mm_a", int'(mm_a), sa);
    chk("t6_mm_b", int'(mm_b), sb);
    chk("t6_result", int'(result), sr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
